// File: rtl/mips32_rtype_exec_unit.sv
// MIPS32 R-type execution unit: 32x32 register file, four-state
// accept/decode/execute/writeback sequencer, one result per four cycles.
module mips32_rtype_exec_unit #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              out_valid,
    output logic              overflow,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    state_e            state_q, state_d;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [4:0]        shamt_q, rd_q;
    logic [5:0]        funct_q;
    logic              op_ill_q;
    logic [DATA_W-1:0] result_q, res_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;
    logic [DATA_W-1:0] rf_q [REG_N];

    logic [5:0]        dec_op;
    logic [4:0]        dec_rs, dec_rt;
    logic [DATA_W-1:0] sum, diff;
    logic              wb_en;

    assign dec_op = instr_q[31:26];
    assign dec_rs = instr_q[25:21];
    assign dec_rt = instr_q[20:16];

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_WB);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

    // Overflowing or illegal results are reported but never committed.
    assign wb_en = (state_q == S_WB) && (rd_q != 5'd0)
                   && !ovf_q && !ill_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum   = a_q + b_q;
        diff  = a_q - b_q;
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = op_ill_q;
        if (!op_ill_q) begin
            case (funct_q)
                F_ADD: begin
                    res_d = sum;
                    ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1])
                            && (sum[DATA_W-1] != a_q[DATA_W-1]);
                end
                F_ADDU: res_d = sum;
                F_SUB: begin
                    res_d = diff;
                    ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1])
                            && (diff[DATA_W-1] != a_q[DATA_W-1]);
                end
                F_SUBU:  res_d = diff;
                F_AND:   res_d = a_q & b_q;
                F_OR:    res_d = a_q | b_q;
                F_NOR:   res_d = ~(a_q | b_q);
                F_SLT:   res_d[0] = $signed(a_q) < $signed(b_q);
                F_SLTU:  res_d[0] = a_q < b_q;
                F_SLL:   res_d = b_q << shamt_q;
                F_SRL:   res_d = b_q >> shamt_q;
                F_SRA:   res_d = $signed(b_q) >>> shamt_q;
                default: ill_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            rd_q     <= '0;
            funct_q  <= '0;
            op_ill_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            // Register i resets to i so tests start from known operands.
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                instr_q <= instr;
            end
            if (state_q == S_DECODE) begin
                a_q      <= (dec_rs == 5'd0) ? '0 : rf_q[dec_rs];
                b_q      <= (dec_rt == 5'd0) ? '0 : rf_q[dec_rt];
                rd_q     <= instr_q[15:11];
                shamt_q  <= instr_q[10:6];
                funct_q  <= instr_q[5:0];
                op_ill_q <= (dec_op != 6'd0);
            end
            if (state_q == S_EXEC) begin
                result_q <= res_d;
                ovf_q    <= ovf_d;
                ill_q    <= ill_d;
            end
            if (wb_en) begin
                rf_q[rd_q] <= result_q;
            end
        end
    end

endmodule

// File: tb/tb_mips32_rtype_exec_unit.sv
// Bench for mips32_rtype_exec_unit: scoreboard of expected results,
// popped and compared whenever the unit pulses out_valid.
module tb_mips32_rtype_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        overflow;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   nvalid = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    mips32_rtype_exec_unit #(.DATA_W(32), .REG_N(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr(instr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .result(result),
        .out_valid(out_valid),
        .overflow(overflow),
        .illegal(illegal),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sh, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                check("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] res,
                         input logic ovf, input logic ill);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        instr    = ins;
        in_valid = 1'b1;
        sb.push_back('{res, ovf, ill, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input string tag, input logic [4:0] a,
                       input logic [31:0] exp);
        dbg_addr = a;
        #1 check(tag, dbg_data, exp);
    endtask

    logic [31:0] tp [3];
    int          base;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, overflow, illegal}, 32'd0);
        dbg("rst_r5", 5'd5, 32'd5);

        issue(rtype(5'd16, 5'd17, 5'd18, 5'd0, 6'b100000), 32'd33, 0, 0);
        drain();
        dbg("add_r18", 5'd18, 32'd33);

        issue(rtype(5'd0, 5'd16, 5'd19, 5'd27, 6'b000000),
              32'h8000_0000, 0, 0);
        issue(rtype(5'd19, 5'd1, 5'd20, 5'd0, 6'b100010),
              32'h7FFF_FFFF, 1, 0);
        drain();
        dbg("sub_ovf_r20", 5'd20, 32'd20);
        issue(rtype(5'd19, 5'd1, 5'd20, 5'd0, 6'b100011),
              32'h7FFF_FFFF, 0, 0);
        drain();
        dbg("subu_r20", 5'd20, 32'h7FFF_FFFF);

        issue(rtype(5'd16, 5'd17, 5'd1, 5'd0, 6'b100111),
              32'hFFFF_FFEE, 0, 0);
        issue(rtype(5'd19, 5'd16, 5'd3, 5'd0, 6'b101011), 32'd0, 0, 0);
        issue(rtype(5'd19, 5'd16, 5'd4, 5'd0, 6'b101010), 32'd1, 0, 0);
        issue(rtype(5'd0, 5'd19, 5'd5, 5'd4, 6'b000011),
              32'hF800_0000, 0, 0);
        issue(rtype(5'd19, 5'd19, 5'd9, 5'd0, 6'b100001), 32'd0, 0, 0);
        issue(rtype(5'd19, 5'd19, 5'd10, 5'd0, 6'b100000), 32'd0, 1, 0);
        drain();
        dbg("nor_r1", 5'd1, 32'hFFFF_FFEE);
        dbg("sltu_r3", 5'd3, 32'd0);
        dbg("slt_r4", 5'd4, 32'd1);
        dbg("sra_r5", 5'd5, 32'hF800_0000);
        dbg("addu_r9", 5'd9, 32'd0);
        dbg("add_ovf_r10", 5'd10, 32'd10);

        issue(rtype(5'd16, 5'd17, 5'd0, 5'd0, 6'b100000), 32'd33, 0, 0);
        issue({6'b001000, 5'd16, 5'd21, 16'd5}, 32'd0, 0, 1);
        issue(rtype(5'd16, 5'd17, 5'd22, 5'd0, 6'b001000), 32'd0, 0, 1);
        drain();
        dbg("r0_zero", 5'd0, 32'd0);
        dbg("opc_ill_r21", 5'd21, 32'd21);
        dbg("fn_ill_r22", 5'd22, 32'd22);

        tp[0] = rtype(5'd16, 5'd17, 5'd6, 5'd0, 6'b100100);
        tp[1] = rtype(5'd16, 5'd17, 5'd7, 5'd0, 6'b100101);
        tp[2] = rtype(5'd0, 5'd19, 5'd8, 5'd4, 6'b000010);
        base = nvalid;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("in_ready_pat", {31'd0, in_ready},
                  (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k % 4 == 0) begin
                instr    = tp[k / 4];
                in_valid = 1'b1;
                case (k / 4)
                    0: sb.push_back('{32'd16, 1'b0, 1'b0, cyc + 1});
                    1: sb.push_back('{32'd17, 1'b0, 1'b0, cyc + 1});
                    default:
                        sb.push_back('{32'h0800_0000, 1'b0, 1'b0, cyc + 1});
                endcase
            end
            if (k == 11) in_valid = 1'b0;
        end
        drain();
        check("pulse_count", 32'(nvalid - base), 32'd3);
        dbg("and_r6", 5'd6, 32'd16);
        dbg("or_r7", 5'd7, 32'd17);
        dbg("srl_r8", 5'd8, 32'h0800_0000);

        base = nvalid;
        @(negedge clk);
        instr    = rtype(5'd16, 5'd17, 5'd18, 5'd0, 6'b100000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        dbg("abort_r18", 5'd18, 32'd18);
        dbg("abort_r1", 5'd1, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_pulse", 32'(nvalid - base), 32'd0);
        check("abort_ready_after", {31'd0, in_ready}, 32'd1);
        dbg("abort_r18_after", 5'd18, 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
